// File: rtl/ide_pkg.sv
// Shared definitions for the IDE transfer controller: state encoding,
// sector geometry and the timeout counter width.
package ide_pkg;

  localparam int SECTOR_WORDS = 256;
  localparam int TIMEOUT_BITS = 20;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    XFER,
    DRAIN,
    DONE
  } xfer_state_t;

  // A sector count of zero in the command register means 256 sectors.
  function automatic logic [8:0] load_count(input logic [7:0] n);
    return (n == 8'd0) ? 9'd256 : {1'b0, n};
  endfunction

endpackage

// File: rtl/ide_strobe_edge.sv
// Falling-edge detector for a gated host data strobe; the history register
// only advances on clk_en cycles, so the pulse is qualified by clk_en.
module ide_strobe_edge (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic strobe,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
    end else if (clk_en) begin
      prev <= strobe;
    end
  end

  assign fall = clk_en & prev & ~strobe;

endmodule

// File: rtl/ide_xfer_ctrl.sv
// IDE PIO data-transfer sequencer between host strobes and the sector FIFO.
// Optional FILL/DRAIN watchdog enabled by defining IDE_XFER_TIMEOUT_EN.
module ide_xfer_ctrl
  import ide_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       cmd_start,
  input  logic       cmd_dir,
  input  logic [7:0] sector_count,
  input  logic       host_rd,
  input  logic       host_wr,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       fifo_wr,
  output logic       fifo_reset,
  output logic       bsy,
  output logic       drq,
  output logic       irq,
  output logic       hdd_req,
  output logic       error,
  output logic [8:0] sectors_left,
  output logic [7:0] word_cnt
);

  xfer_state_t state, state_next;
  logic       dir;
  logic       rd_fall, wr_fall, word_done, wrap;
  logic       start_ok, dec_sectors, irq_set, irq_clr, timeout;
  logic [8:0] sectors_dec;

  // Strobes reach the FIFO only while the host is allowed to move data.
  assign fifo_rd     = host_rd & drq & dir;
  assign fifo_wr     = host_wr & drq & ~dir;
  assign word_done   = (rd_fall | wr_fall) & (state == XFER);
  assign wrap        = word_done & (word_cnt == 8'(SECTOR_WORDS - 1));
  assign sectors_dec = sectors_left - 9'd1;

  ide_strobe_edge u_rd_edge (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .strobe (fifo_rd),
    .fall   (rd_fall)
  );

  ide_strobe_edge u_wr_edge (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .strobe (fifo_wr),
    .fall   (wr_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    bsy         = 1'b0;
    drq         = 1'b0;
    hdd_req     = 1'b0;
    start_ok    = 1'b0;
    dec_sectors = 1'b0;
    irq_set     = 1'b0;
    irq_clr     = 1'b0;
    case (state)
      IDLE: begin
        irq_clr = host_rd | host_wr | cmd_start;
        if (cmd_start) begin
          start_ok   = 1'b1;
          state_next = cmd_dir ? FILL : XFER;
        end
      end
      FILL: begin
        bsy     = 1'b1;
        hdd_req = 1'b1;
        if (fifo_full) begin
          irq_set    = 1'b1;
          state_next = XFER;
        end else if (timeout) begin
          irq_set    = 1'b1;
          state_next = IDLE;
        end
      end
      XFER: begin
        drq = 1'b1;
        // Flags are not looked at here, so a sector wrap always wins.
        if (wrap) begin
          if (dir) begin
            dec_sectors = 1'b1;
            state_next  = (sectors_dec == 9'd0) ? DONE : FILL;
          end else begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        bsy     = 1'b1;
        hdd_req = 1'b1;
        if (fifo_empty) begin
          dec_sectors = 1'b1;
          irq_set     = 1'b1;
          state_next  = (sectors_dec == 9'd0) ? DONE : XFER;
        end else if (timeout) begin
          irq_set    = 1'b1;
          state_next = IDLE;
        end
      end
      DONE: begin
        irq_clr    = host_rd | host_wr;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir          <= 1'b0;
      fifo_reset   <= 1'b0;
      irq          <= 1'b0;
      sectors_left <= 9'd0;
      word_cnt     <= 8'd0;
    end else if (clk_en) begin
      fifo_reset <= start_ok;
      if (start_ok) begin
        dir          <= cmd_dir;
        sectors_left <= load_count(sector_count);
      end else if (dec_sectors) begin
        sectors_left <= sectors_dec;
      end
      if (start_ok) begin
        word_cnt <= 8'd0;
      end else if (word_done) begin
        word_cnt <= word_cnt + 8'd1;
      end
      if (irq_set) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end

`ifdef IDE_XFER_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] wait_cnt;

  // Counts cycles spent waiting on firmware; restarts whenever the state changes.
  assign timeout = ((state == FILL) || (state == DRAIN)) & (&wait_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      error    <= 1'b0;
    end else if (clk_en) begin
      if ((state_next != state) || !((state == FILL) || (state == DRAIN))) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (start_ok) begin
        error <= 1'b0;
      end else if (timeout && (state_next == IDLE)) begin
        error <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_ide_xfer_ctrl.sv
// Self-checking bench for ide_xfer_ctrl: a phase-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ide_xfer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_en = 1'b1;
  logic       cmd_start = 1'b0;
  logic       cmd_dir = 1'b0;
  logic [7:0] sector_count = 8'd0;
  logic       host_rd = 1'b0;
  logic       host_wr = 1'b0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty = 1'b0;
  logic       fifo_rd, fifo_wr, fifo_reset, bsy, drq, irq, hdd_req, error;
  logic [8:0] sectors_left;
  logic [7:0] word_cnt;

  int n_checks = 0;
  int n_errors = 0;

`ifdef IDE_XFER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TMAX = (1 << 20) - 1;

  always #5 clk = ~clk;

  ide_xfer_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .cmd_start    (cmd_start),
    .cmd_dir      (cmd_dir),
    .sector_count (sector_count),
    .host_rd      (host_rd),
    .host_wr      (host_wr),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_rd      (fifo_rd),
    .fifo_wr      (fifo_wr),
    .fifo_reset   (fifo_reset),
    .bsy          (bsy),
    .drq          (drq),
    .irq          (irq),
    .hdd_req      (hdd_req),
    .error        (error),
    .sectors_left (sectors_left),
    .word_cnt     (word_cnt)
  );

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transfer phase, words moved in the current sector and
  // sectors still owed, advanced on each enabled clock from the sampled inputs.
  typedef enum int {M_IDLE, M_FILL, M_XFER, M_DRAIN, M_DONE} mphase_t;
  mphase_t ph = M_IDLE;
  mphase_t ph_before = M_IDLE;
  int  left = 0;
  int  words = 0;
  int  dwell = 0;
  bit  mirq = 0, mdir = 0, mfrst = 0, merr = 0;
  bit  prev_rd = 0, prev_wr = 0, m_rdg = 0, m_wrg = 0, m_fell = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = M_IDLE; left = 0; words = 0; dwell = 0;
      mirq = 0; mdir = 0; mfrst = 0; merr = 0; prev_rd = 0; prev_wr = 0;
    end else if (clk_en) begin
      m_rdg   = host_rd && (ph == M_XFER) && mdir;
      m_wrg   = host_wr && (ph == M_XFER) && !mdir;
      m_fell  = (prev_rd && !m_rdg) || (prev_wr && !m_wrg);
      prev_rd = m_rdg;
      prev_wr = m_wrg;
      mfrst   = 0;
      ph_before = ph;
      case (ph)
        M_IDLE: begin
          if (host_rd || host_wr) mirq = 0;
          if (cmd_start) begin
            left  = (sector_count == 0) ? 256 : int'(sector_count);
            words = 0; mirq = 0; mfrst = 1; merr = 0; mdir = cmd_dir;
            ph    = cmd_dir ? M_FILL : M_XFER;
          end
        end
        M_FILL: begin
          if (fifo_full) begin ph = M_XFER; mirq = 1; end
          else if (TO_EN && dwell == TMAX) begin ph = M_IDLE; mirq = 1; merr = 1; end
        end
        M_XFER: begin
          if (m_fell) begin
            words++;
            if (words == 256) begin
              words = 0;
              if (mdir) begin
                left--;
                ph = (left == 0) ? M_DONE : M_FILL;
              end else begin
                ph = M_DRAIN;
              end
            end
          end
        end
        M_DRAIN: begin
          if (fifo_empty) begin
            left--; mirq = 1;
            ph = (left == 0) ? M_DONE : M_XFER;
          end else if (TO_EN && dwell == TMAX) begin ph = M_IDLE; mirq = 1; merr = 1; end
        end
        M_DONE: begin
          if (host_rd || host_wr) mirq = 0;
          ph = M_IDLE;
        end
        default: ph = M_IDLE;
      endcase
      if ((ph == ph_before) && (ph == M_FILL || ph == M_DRAIN)) dwell++;
      else dwell = 0;
    end
  end

  // Every cycle: outputs must match the model's phase and counters.
  always @(negedge clk) begin
    check_output("bsy", bsy, int'(ph == M_FILL || ph == M_DRAIN));
    check_output("hdd_req", hdd_req, int'(ph == M_FILL || ph == M_DRAIN));
    check_output("drq", drq, int'(ph == M_XFER));
    check_output("irq", irq, int'(mirq));
    check_output("error", error, int'(merr));
    check_output("fifo_reset", fifo_reset, int'(mfrst));
    check_output("fifo_rd", fifo_rd, int'(host_rd && ph == M_XFER && mdir));
    check_output("fifo_wr", fifo_wr, int'(host_wr && ph == M_XFER && !mdir));
    check_output("sectors_left", sectors_left, left);
    check_output("word_cnt", word_cnt, words);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input bit dir, input logic [7:0] count);
    cmd_dir      = dir;
    sector_count = count;
    cmd_start    = 1'b1;
    tick(1);
    cmd_start    = 1'b0;
  endtask

  task automatic pulse_words(input bit rd, input int n);
    for (int i = 0; i < n; i++) begin
      if (rd) host_rd = 1'b1; else host_wr = 1'b1;
      tick(1);
      host_rd = 1'b0;
      host_wr = 1'b0;
      tick(1);
    end
  endtask

  task automatic pulse_full();
    fifo_full = 1'b1;
    tick(1);
    fifo_full = 1'b0;
  endtask

  task automatic pulse_empty();
    fifo_empty = 1'b1;
    tick(1);
    fifo_empty = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check_output("rst_bsy", bsy, 0);
    check_output("rst_sectors", sectors_left, 0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Two-sector read.
    apply_stimulus(1'b1, 8'd2);
    check_output("rd_fifo_reset", fifo_reset, 1);
    check_output("rd_fill_bsy", bsy, 1);
    check_output("rd_fill_hdd", hdd_req, 1);
    check_output("rd_load", sectors_left, 2);
    tick(10);
    pulse_full();
    check_output("rd_drq", drq, 1);
    check_output("rd_irq", irq, 1);
    check_output("rd_xfer_bsy", bsy, 0);
    pulse_words(1'b1, 256);
    check_output("rd_sec1_left", sectors_left, 1);
    check_output("rd_refill_bsy", bsy, 1);
    check_output("rd_refill_drq", drq, 0);
    tick(3);
    pulse_full();
    pulse_words(1'b1, 256);
    check_output("rd_done_left", sectors_left, 0);
    check_output("rd_done_bsy", bsy, 0);
    check_output("rd_done_drq", drq, 0);
    tick(1);
    check_output("rd_idle_irq", irq, 1);

    // One-sector write.
    apply_stimulus(1'b0, 8'd1);
    check_output("wr_drq", drq, 1);
    check_output("wr_irq_clr", irq, 0);
    pulse_words(1'b0, 256);
    check_output("wr_drain_hdd", hdd_req, 1);
    check_output("wr_drain_bsy", bsy, 1);
    tick(2);
    pulse_empty();
    check_output("wr_irq", irq, 1);
    check_output("wr_left", sectors_left, 0);
    tick(1);
    check_output("wr_idle_bsy", bsy, 0);

    // Sector count of zero, continuing through DRAIN back into XFER.
    apply_stimulus(1'b0, 8'd0);
    check_output("zero_load", sectors_left, 256);
    pulse_words(1'b0, 256);
    pulse_empty();
    check_output("zero_left", sectors_left, 255);
    check_output("zero_drq", drq, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);

    // Strobes during FILL, clock-enable freeze, ignored command, async reset.
    apply_stimulus(1'b1, 8'd1);
    host_rd = 1'b1;
    #1 check_output("fill_fifo_rd", fifo_rd, 0);
    tick(2);
    host_rd = 1'b0;
    tick(1);
    check_output("fill_word_cnt", word_cnt, 0);
    clk_en    = 1'b0;
    fifo_full = 1'b1;
    tick(3);
    check_output("freeze_drq", drq, 0);
    clk_en = 1'b1;
    tick(1);
    fifo_full = 1'b0;
    check_output("unfreeze_drq", drq, 1);
    pulse_words(1'b1, 100);
    check_output("word100", word_cnt, 100);
    apply_stimulus(1'b1, 8'd5);
    check_output("ign_left", sectors_left, 1);
    check_output("ign_drq", drq, 1);
    host_rd = 1'b1;
    #1 check_output("pre_rst_fifo_rd", fifo_rd, 1);
    #2 reset = 1'b1;
    #1;
    check_output("arst_bsy", bsy, 0);
    check_output("arst_drq", drq, 0);
    check_output("arst_irq", irq, 0);
    check_output("arst_hdd", hdd_req, 0);
    check_output("arst_error", error, 0);
    check_output("arst_fifo_reset", fifo_reset, 0);
    check_output("arst_fifo_rd", fifo_rd, 0);
    check_output("arst_left", sectors_left, 0);
    check_output("arst_word", word_cnt, 0);
    host_rd = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);

`ifdef IDE_XFER_TIMEOUT_EN
    apply_stimulus(1'b1, 8'd1);
    tick(1 << 20);
    tick(2);
    check_output("to_error", error, 1);
    check_output("to_irq", irq, 1);
    check_output("to_bsy", bsy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #30000000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ide_xfer_ctrl.md
IDE_XFER_CTRL -- requirements
Module: ide_xfer_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  bus clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: clk_en  input  1  clock enable; all state, counters and edge detectors advance only when high.
REQ-004 SHALL have ports: cmd_start input 1 (one-cycle command pulse); cmd_dir input 1 (1 = disk-to-host read, 0 = host-to-disk write); sector_count input 8 (0 means 256).
REQ-005 SHALL have ports: host_rd input 1 and host_wr input 1, level strobes from the CPU data-port decoder.
REQ-006 SHALL have ports: fifo_full input 1 and fifo_empty input 1, both from the downstream sector FIFO.
REQ-007 SHALL have ports: fifo_rd output 1, fifo_wr output 1, fifo_reset output 1, all driven to the sector FIFO.
REQ-008 SHALL have ports: bsy output 1, drq output 1, irq output 1 (status/interrupt), hdd_req output 1 (firmware service request), error output 1.
REQ-009 SHALL have ports: sectors_left output 9 (remaining sectors) and word_cnt output 8 (word index within the current sector).

Function
REQ-010 SHALL implement states IDLE, FILL, XFER, DRAIN, DONE.
REQ-011 SHALL, on cmd_start in IDLE, load sectors_left = (sector_count==0 ? 256 : sector_count), clear word_cnt and irq, and pulse fifo_reset for one clk_en cycle.
REQ-012 SHALL ignore cmd_start in any state other than IDLE.
REQ-013 SHALL, for a read command (cmd_dir=1), go IDLE->FILL with bsy=1 and hdd_req=1; on fifo_full go FILL->XFER with bsy=0, drq=1, irq set.
REQ-014 SHALL, for a write command (cmd_dir=0), go IDLE->XFER directly with drq=1 and no irq.
REQ-015 SHALL drive fifo_rd = host_rd & drq & cmd_dir and fifo_wr = host_wr & drq & ~cmd_dir, combinationally; strobes outside XFER are dropped.
REQ-016 SHALL increment word_cnt on each falling edge of the gated strobe (registered previous value vs current), matching FIFO pointer update timing.
REQ-017 SHALL, when word_cnt wraps 255->0 in read mode, decrement sectors_left and go to DONE if the result is 0, otherwise to FILL (drq=0, bsy=1, hdd_req=1).
REQ-018 SHALL, when word_cnt wraps 255->0 in write mode, go XFER->DRAIN with drq=0, bsy=1, hdd_req=1.
REQ-019 SHALL, in DRAIN on fifo_empty, decrement sectors_left, set irq, and go to DONE if the result is 0, otherwise to XFER (drq=1).
REQ-020 SHALL, in DONE, hold bsy=0, drq=0, hdd_req=0 for one clk_en cycle, then return to IDLE; irq remains set.
REQ-021 SHALL clear irq on a host_rd or host_wr while in IDLE or DONE (status read acknowledge), or on cmd_start.
REQ-022 SHALL give priority to the wrap event over fifo_full/fifo_empty when both occur in the same cycle; the flag is re-evaluated in the next state.

Reset
REQ-023 SHALL, on reset assertion, immediately enter IDLE with bsy=0, drq=0, irq=0, hdd_req=0, error=0, fifo_reset=0, sectors_left=0, word_cnt=0, and edge registers=0, including mid-transfer.

Configuration
REQ-024 SHALL, with IDE_XFER_TIMEOUT_EN defined, count clk_en cycles spent in FILL or DRAIN using a 20-bit counter; at 2^20-1 it SHALL set error=1 and irq=1 and go to IDLE; the counter clears on any state exit.
REQ-025 SHALL, without IDE_XFER_TIMEOUT_EN, contain no timeout counter and tie error to 0.

Structure
REQ-026 SHALL take the state enum, SECTOR_WORDS=256 and TIMEOUT_BITS=20 from the shared package ide_pkg.
REQ-027 SHALL instantiate one sub-module, ide_strobe_edge (clk_en-gated falling-edge detector), once each for the gated read and write strobes.

Verification
REQ-028 SHALL verify: read with sector_count=2, fifo_full after 10 cycles -> drq=1, irq=1; 512 host_rd pulses -> sectors_left 2->1->0, DONE, then IDLE.
REQ-029 SHALL verify: write with sector_count=1 -> drq=1 immediately; after 256 host_wr pulses -> DRAIN, hdd_req=1; fifo_empty -> irq=1, sectors_left=0, IDLE.
REQ-030 SHALL verify: sector_count=0 -> sectors_left loads 256.
REQ-031 SHALL verify: reset asserted at word 100 of a read -> all outputs 0 without waiting for a clock edge.
REQ-032 SHALL verify: host_rd while in FILL -> fifo_rd=0 and word_cnt unchanged; cmd_start during XFER is ignored.
REQ-033 SHALL verify, with IDE_XFER_TIMEOUT_EN defined: FILL with no fifo_full for 2^20 clk_en cycles -> error=1, irq=1, IDLE.
